msrv32_branch_predict_unit: RTL and testbench
=============================================

Name: msrv32_branch_predict_unit

Overview:
- Parametrised successor to the combinational branch-resolution logic.
- Resolves RV32I branch/jump outcomes, with signed and unsigned compares handled correctly.
- Holds a BHT of 2-bit saturating counters, indexed by PC, giving a registered taken/not-taken prediction to fetch.
- Flags mispredicts one cycle after resolution. Sits between fetch (predict port) and execute (resolve port).

Parameters:
- WIDTH, 32, data/PC width in bits.
- BHT_ENTRIES, 64, number of counters; power of two, >= 2.
- IDX_WIDTH, $clog2(BHT_ENTRIES), index width; derived, not to be overridden.
- PERF_WIDTH, 32, width of the performance counters (optional feature only).

Ports:
- ms_riscv32_mp_clk_in  input  1  clock; all state changes on the rising edge.
- ms_riscv32_mp_rst_in  input  1  reset; synchronous, active-low.
- pred_valid_in  input  1  fetch requests a prediction this cycle.
- pred_pc_in  input  WIDTH  PC of the fetched instruction.
- pred_valid_out  output  1  registered; prediction valid.
- pred_taken_out  output  1  registered; predicted taken.
- res_valid_in  input  1  execute has a valid instruction to resolve.
- res_pc_in  input  WIDTH  PC of the resolving instruction.
- rs1_in, rs2_in  input  WIDTH  operands.
- opcode_6_to_2_in  input  5  opcode[6:2].
- funct3_in  input  3  funct3.
- res_pred_taken_in  input  1  prediction originally issued for this instruction.
- branch_taken_out  output  1  combinational resolved outcome.
- illegal_branch_out  output  1  combinational; branch opcode with funct3 010/011.
- mispredict_out  output  1  registered mispredict pulse.
- ready_out  output  1  BHT initialised.
- branch_cnt_out  output  PERF_WIDTH  resolved-control-transfer count.
- mispred_cnt_out  output  PERF_WIDTH  mispredict count.

Behaviour:
- Reset (rst_in==0 at an edge): FSM enters INIT with sweep index 0. All registered outputs go to 0: pred_valid_out, pred_taken_out, mispredict_out, ready_out, both counters.
- FSM INIT: each cycle writes 2'b01 (weakly not-taken) to BHT[sweep], then increments sweep.
  - When sweep==BHT_ENTRIES-1 is written, go to READY.
  - ready_out=1 from the cycle after the last write. INIT lasts exactly BHT_ENTRIES cycles after reset release.
- Reset asserted during INIT restarts the sweep at 0. READY is left only by reset.
- Index for both ports: pc[IDX_WIDTH+1:2]. PC bits [1:0] and the upper bits are ignored, so aliasing is permitted.
- Resolution (combinational, every path assigned, no latches):
  - opcode 11000, funct3 000 BEQ (==), 001 BNE (!=): taken per compare.
  - 100 BLT: signed <. 101 BGE: signed >=. 110 BLTU: unsigned <. 111 BGEU: unsigned >=.
  - 010/011: not taken, illegal_branch_out=1.
  - opcode 11011 (JAL): taken.
  - opcode 11001 (JALR): taken iff funct3==000.
  - Any other opcode: not taken.
  - illegal_branch_out=0 except the reserved branch funct3 cases.
- Predict, 1-cycle latency:
  - pred_valid_out <= pred_valid_in & ready.
  - pred_taken_out <= pred_valid_in & ready & BHT[idx][1].
  - Not ready: both 0.
- Update: in READY, res_valid_in with opcode 11000 and a legal funct3 updates BHT[res idx].
  - Taken: saturating increment (11 stays 11). Not taken: saturating decrement (00 stays 00).
  - JAL/JALR/illegal never update. During INIT, updates are dropped.
- Same-cycle predict and update to the same index: the prediction uses the post-update counter value (bypass).
- mispredict_out <= res_valid_in & ready & counted & (branch_taken_out != res_pred_taken_in).
  - counted = conditional legal branch, or JAL, or JALR with funct3 000.
  - Pulses for one cycle per event. Back-to-back events give back-to-back pulses.
- No stall input: the caller gates the valid inputs.

Optional Feature:
- MSRV32_BP_PERF_EN defined:
  - branch_cnt_out increments on every counted resolution while ready.
  - mispred_cnt_out increments on every cycle that sets mispredict_out.
  - Both wrap modulo 2^PERF_WIDTH, clear on reset, and hold during INIT.
- Undefined: both ports remain and are tied to 0; no counter flops are synthesised.

Test Plan:
- Release reset with BHT_ENTRIES=64 -> ready_out low for 64 cycles, high on cycle 65. Pulse reset at cycle 30 -> ready_out rises 64 cycles after the second release.
- rs1=0xFFFFFFFF, rs2=0x00000001 -> BLT taken, BGE not taken, BLTU not taken, BGEU taken. rs1=rs2=5 -> BEQ 1, BNE 0. funct3 010 -> taken 0, illegal 1.
- Predict pc 0x100 after init -> pred_taken_out 0. Then 2 taken BEQ updates at 0x100 -> predict 1. 3 further taken then 4 not-taken -> counter 00, predict 0 (saturation both ends).
- Alias: update pc 0x200 taken twice -> predict at pc 0x100 returns 1 (shared idx 0). Predict and update 0x100 in the same cycle -> prediction reflects the bypassed new value.
- JAL with res_pred_taken_in=0 -> mispredict_out=1 next cycle, BHT unchanged. BEQ taken with predicted=1 -> no pulse. JALR funct3 001 -> taken 0.
- With MSRV32_BP_PERF_EN, PERF_WIDTH=4: 17 counted branches, 3 mispredicted -> branch_cnt_out 1 (wrapped), mispred_cnt_out 3. Without the macro -> both 0.

Source files
------------

// File: rtl/msrv32_branch_predict_unit.sv
// RV32I branch resolution with a PC-indexed BHT of 2-bit counters; prediction and mispredict are registered (1 cycle).
// Optional performance counters are enabled by defining MSRV32_BP_PERF_EN; no backpressure, callers gate the valids.
module msrv32_branch_predict_unit #(
  parameter int WIDTH       = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_WIDTH   = $clog2(BHT_ENTRIES),
  parameter int PERF_WIDTH  = 32
) (
  input  logic                  ms_riscv32_mp_clk_in,
  input  logic                  ms_riscv32_mp_rst_in,
  input  logic                  pred_valid_in,
  input  logic [WIDTH-1:0]      pred_pc_in,
  output logic                  pred_valid_out,
  output logic                  pred_taken_out,
  input  logic                  res_valid_in,
  input  logic [WIDTH-1:0]      res_pc_in,
  input  logic [WIDTH-1:0]      rs1_in,
  input  logic [WIDTH-1:0]      rs2_in,
  input  logic [4:0]            opcode_6_to_2_in,
  input  logic [2:0]            funct3_in,
  input  logic                  res_pred_taken_in,
  output logic                  branch_taken_out,
  output logic                  illegal_branch_out,
  output logic                  mispredict_out,
  output logic                  ready_out,
  output logic [PERF_WIDTH-1:0] branch_cnt_out,
  output logic [PERF_WIDTH-1:0] mispred_cnt_out
);

  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t               state_q;
  logic [IDX_WIDTH-1:0] sweep_q;
  logic [1:0]           bht_q [BHT_ENTRIES];
  logic                 pred_valid_q, pred_taken_q, mispredict_q;
  logic                 pred_valid_d, pred_taken_d, mispredict_d;

  logic                 ready;
  logic                 is_cond, counted;
  logic [IDX_WIDTH-1:0] pred_idx, res_idx;
  logic                 upd_en;
  logic [1:0]           upd_cur, upd_val, pred_ctr;
  logic                 unused_pc_bits;

  assign ready    = (state_q == ST_READY);
  assign pred_idx = pred_pc_in[IDX_WIDTH+1:2];
  assign res_idx  = res_pc_in[IDX_WIDTH+1:2];
  assign unused_pc_bits = ^{pred_pc_in[WIDTH-1:IDX_WIDTH+2], pred_pc_in[1:0],
                            res_pc_in[WIDTH-1:IDX_WIDTH+2], res_pc_in[1:0]};

  always_comb begin
    branch_taken_out   = 1'b0;
    illegal_branch_out = 1'b0;
    is_cond            = 1'b0;
    counted            = 1'b0;
    case (opcode_6_to_2_in)
      OP_BRANCH: begin
        is_cond = 1'b1;
        case (funct3_in)
          3'b000:  branch_taken_out = (rs1_in == rs2_in);
          3'b001:  branch_taken_out = (rs1_in != rs2_in);
          3'b100:  branch_taken_out = ($signed(rs1_in) <  $signed(rs2_in));
          3'b101:  branch_taken_out = ($signed(rs1_in) >= $signed(rs2_in));
          3'b110:  branch_taken_out = (rs1_in <  rs2_in);
          3'b111:  branch_taken_out = (rs1_in >= rs2_in);
          default: begin
            illegal_branch_out = 1'b1;
            is_cond            = 1'b0;
          end
        endcase
        counted = is_cond;
      end
      OP_JAL: begin
        branch_taken_out = 1'b1;
        counted          = 1'b1;
      end
      OP_JALR: begin
        branch_taken_out = (funct3_in == 3'b000);
        counted          = (funct3_in == 3'b000);
      end
      default: ;
    endcase
  end

  // Saturating counter update; a same-index predict sees the updated value.
  assign upd_en  = ready & res_valid_in & is_cond;
  assign upd_cur = bht_q[res_idx];
  always_comb begin
    upd_val = upd_cur;
    if (branch_taken_out) begin
      if (upd_cur != 2'b11) upd_val = upd_cur + 2'b01;
    end else begin
      if (upd_cur != 2'b00) upd_val = upd_cur - 2'b01;
    end
  end
  assign pred_ctr = (upd_en && (res_idx == pred_idx)) ? upd_val : bht_q[pred_idx];

  assign pred_valid_d = pred_valid_in & ready;
  assign pred_taken_d = pred_valid_in & ready & pred_ctr[1];
  assign mispredict_d = res_valid_in & ready & counted & (branch_taken_out != res_pred_taken_in);

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      state_q      <= ST_INIT;
      sweep_q      <= '0;
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      mispredict_q <= 1'b0;
    end else begin
      if (state_q == ST_INIT) begin
        sweep_q <= sweep_q + IDX_WIDTH'(1);
        if (sweep_q == IDX_WIDTH'(BHT_ENTRIES - 1)) state_q <= ST_READY;
      end
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      mispredict_q <= mispredict_d;
    end
  end

  // Table contents need no reset: the INIT sweep rewrites every entry.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (state_q == ST_INIT) bht_q[sweep_q] <= 2'b01;
    else if (upd_en)        bht_q[res_idx] <= upd_val;
  end

  assign pred_valid_out = pred_valid_q;
  assign pred_taken_out = pred_taken_q;
  assign mispredict_out = mispredict_q;
  assign ready_out      = ready;

`ifdef MSRV32_BP_PERF_EN
  logic [PERF_WIDTH-1:0] branch_cnt_q, mispred_cnt_q;

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (ready & res_valid_in & counted) branch_cnt_q  <= branch_cnt_q + PERF_WIDTH'(1);
      if (mispredict_d)                   mispred_cnt_q <= mispred_cnt_q + PERF_WIDTH'(1);
    end
  end

  assign branch_cnt_out  = branch_cnt_q;
  assign mispred_cnt_out = mispred_cnt_q;
`else
  assign branch_cnt_out  = '0;
  assign mispred_cnt_out = '0;
`endif

endmodule

// File: tb/tb_msrv32_branch_predict_unit.sv
// Directed bench for msrv32_branch_predict_unit with a behavioural reference model checked every cycle.
module tb_msrv32_branch_predict_unit;

  localparam int PW = 4;
  localparam int NENT = 64;
  localparam logic [4:0] OP_BR   = 5'b11000;
  localparam logic [4:0] OP_JAL  = 5'b11011;
  localparam logic [4:0] OP_JALR = 5'b11001;

  logic          clk;
  logic          rst_n;
  logic          pred_valid_in;
  logic [31:0]   pred_pc_in;
  logic          pred_valid_out, pred_taken_out;
  logic          res_valid_in;
  logic [31:0]   res_pc_in, rs1_in, rs2_in;
  logic [4:0]    opcode_in;
  logic [2:0]    funct3_in;
  logic          res_pred_taken_in;
  logic          branch_taken_out, illegal_branch_out, mispredict_out, ready_out;
  logic [PW-1:0] branch_cnt_out, mispred_cnt_out;

  int checks = 0;
  int errors = 0;

  msrv32_branch_predict_unit #(.WIDTH(32), .BHT_ENTRIES(NENT), .PERF_WIDTH(PW)) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .pred_valid_in        (pred_valid_in),
    .pred_pc_in           (pred_pc_in),
    .pred_valid_out       (pred_valid_out),
    .pred_taken_out       (pred_taken_out),
    .res_valid_in         (res_valid_in),
    .res_pc_in            (res_pc_in),
    .rs1_in               (rs1_in),
    .rs2_in               (rs2_in),
    .opcode_6_to_2_in     (opcode_in),
    .funct3_in            (funct3_in),
    .res_pred_taken_in    (res_pred_taken_in),
    .branch_taken_out     (branch_taken_out),
    .illegal_branch_out   (illegal_branch_out),
    .mispredict_out       (mispredict_out),
    .ready_out            (ready_out),
    .branch_cnt_out       (branch_cnt_out),
    .mispred_cnt_out      (mispred_cnt_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Outcome rules of the control-transfer instructions.
  function automatic void resolve(input logic [4:0] op, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output bit tk, output bit il, output bit ct, output bit cd);
    tk = 0; il = 0; ct = 0; cd = 0;
    if (op == OP_BR) begin
      case (f3)
        3'd0: tk = (a == b);
        3'd1: tk = (a != b);
        3'd4: tk = ($signed(a) <  $signed(b));
        3'd5: tk = ($signed(a) >= $signed(b));
        3'd6: tk = (a <  b);
        3'd7: tk = (a >= b);
        default: il = 1;
      endcase
      cd = !il;
      ct = cd;
    end else if (op == OP_JAL) begin
      tk = 1; ct = 1;
    end else if (op == OP_JALR) begin
      tk = (f3 == 3'd0); ct = tk;
    end
  endfunction

  // Reference model state
  bit mvalid = 0;
  bit m_ready = 0;
  int init_cnt = 0;
  int mbht [NENT];
  bit exp_pv = 0, exp_pt = 0, exp_mp = 0;
  int exp_bc = 0, exp_mc = 0;

  always @(posedge clk) begin : model
    bit tk, il, ct, cd, rdy;
    int pidx, ridx;
    if (!rst_n) begin
      mvalid = 1; m_ready = 0; init_cnt = 0;
      exp_pv = 0; exp_pt = 0; exp_mp = 0; exp_bc = 0; exp_mc = 0;
    end else begin
      rdy = m_ready;
      resolve(opcode_in, funct3_in, rs1_in, rs2_in, tk, il, ct, cd);
      pidx = int'((pred_pc_in >> 2) % NENT);
      ridx = int'((res_pc_in >> 2) % NENT);
      if (rdy && res_valid_in && cd) begin
        if (tk) mbht[ridx] = (mbht[ridx] >= 3) ? 3 : mbht[ridx] + 1;
        else    mbht[ridx] = (mbht[ridx] <= 0) ? 0 : mbht[ridx] - 1;
      end
      exp_pv = pred_valid_in && rdy;
      exp_pt = exp_pv && (mbht[pidx] >= 2);
      exp_mp = res_valid_in && rdy && ct && (tk != res_pred_taken_in);
`ifdef MSRV32_BP_PERF_EN
      if (rdy && res_valid_in && ct) exp_bc = (exp_bc + 1) % (1 << PW);
      if (exp_mp) exp_mc = (exp_mc + 1) % (1 << PW);
`endif
      if (!rdy) begin
        init_cnt++;
        if (init_cnt == NENT) begin
          m_ready = 1;
          for (int i = 0; i < NENT; i++) mbht[i] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin : compare
    bit tk, il, ct, cd;
    if (mvalid) begin
      resolve(opcode_in, funct3_in, rs1_in, rs2_in, tk, il, ct, cd);
      check("pred_valid", {31'b0, pred_valid_out}, {31'b0, exp_pv});
      check("pred_taken", {31'b0, pred_taken_out}, {31'b0, exp_pt});
      check("mispredict", {31'b0, mispredict_out}, {31'b0, exp_mp});
      check("ready", {31'b0, ready_out}, {31'b0, m_ready});
      check("branch_taken", {31'b0, branch_taken_out}, {31'b0, tk});
      check("illegal", {31'b0, illegal_branch_out}, {31'b0, il});
      check("branch_cnt", 32'(branch_cnt_out), 32'(exp_bc));
      check("mispred_cnt", 32'(mispred_cnt_out), 32'(exp_mc));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic set_pred(input logic v, input logic [31:0] pc);
    pred_valid_in = v;
    pred_pc_in    = pc;
  endtask

  task automatic set_res(input logic v, input logic [31:0] pc, input logic [4:0] op,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic pt);
    res_valid_in = v; res_pc_in = pc; opcode_in = op; funct3_in = f3;
    rs1_in = a; rs2_in = b; res_pred_taken_in = pt;
  endtask

  task automatic res_chk(input string name, input logic [4:0] op, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic exp_tk, input logic exp_il);
    set_res(1'b0, 32'h0, op, f3, a, b, 1'b0);
    tick();
    check(name, {30'b0, branch_taken_out, illegal_branch_out}, {30'b0, exp_tk, exp_il});
  endtask

  task automatic predict(input logic [31:0] pc, input logic exp_tk, input string name);
    set_res(1'b0, 32'h0, 5'b0, 3'b0, 32'h0, 32'h0, 1'b0);
    set_pred(1'b1, pc);
    tick();
    check(name, {30'b0, pred_valid_out, pred_taken_out}, {30'b0, 1'b1, exp_tk});
    set_pred(1'b0, 32'h0);
  endtask

  // BEQ updates whose prediction matches the outcome.
  task automatic update(input logic [31:0] pc, input logic tk, input int n);
    set_res(1'b1, pc, OP_BR, 3'b000, 32'h0, tk ? 32'h0 : 32'h1, tk);
    repeat (n) tick();
    set_res(1'b0, 32'h0, 5'b0, 3'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    set_pred(1'b0, 32'h0);
    set_res(1'b0, 32'h0, 5'b0, 3'b0, 32'h0, 32'h0, 1'b0);
    tick(); tick();
    check("reset_ready", {31'b0, ready_out}, 32'd0);
    check("reset_mispredict", {31'b0, mispredict_out}, 32'd0);
    rst_n = 1'b1;
    repeat (NENT - 1) tick();
    check("ready_low_at_64", {31'b0, ready_out}, 32'd0);
    tick();
    check("ready_high_at_65", {31'b0, ready_out}, 32'd1);

    // Reset pulse part-way through INIT, with traffic that must be ignored.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    set_pred(1'b1, 32'h100);
    set_res(1'b1, 32'h100, OP_BR, 3'b000, 32'h7, 32'h7, 1'b0);
    repeat (30) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (NENT - 1) tick();
    check("restart_ready_low", {31'b0, ready_out}, 32'd0);
    check("init_pred_valid", {31'b0, pred_valid_out}, 32'd0);
    tick();
    check("restart_ready_high", {31'b0, ready_out}, 32'd1);
    set_pred(1'b0, 32'h0);
    set_res(1'b0, 32'h0, 5'b0, 3'b0, 32'h0, 32'h0, 1'b0);
    tick();

    res_chk("blt_neg1_1",  OP_BR, 3'd4, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
    res_chk("bge_neg1_1",  OP_BR, 3'd5, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    res_chk("bltu_neg1_1", OP_BR, 3'd6, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    res_chk("bgeu_neg1_1", OP_BR, 3'd7, 32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
    res_chk("beq_5_5",     OP_BR, 3'd0, 32'h5, 32'h5, 1'b1, 1'b0);
    res_chk("bne_5_5",     OP_BR, 3'd1, 32'h5, 32'h5, 1'b0, 1'b0);
    res_chk("br_f3_010",   OP_BR, 3'd2, 32'h5, 32'h5, 1'b0, 1'b1);
    res_chk("br_f3_011",   OP_BR, 3'd3, 32'h5, 32'h6, 1'b0, 1'b1);
    res_chk("jal",         OP_JAL, 3'd5, 32'h0, 32'h0, 1'b1, 1'b0);
    res_chk("jalr_f3_001", OP_JALR, 3'd1, 32'h0, 32'h0, 1'b0, 1'b0);
    res_chk("jalr_f3_000", OP_JALR, 3'd0, 32'h0, 32'h0, 1'b1, 1'b0);
    res_chk("other_op",    5'b01100, 3'd0, 32'h5, 32'h5, 1'b0, 1'b0);

    predict(32'h100, 1'b0, "pred_after_init");
    update(32'h100, 1'b1, 2);
    predict(32'h100, 1'b1, "pred_after_2_taken");
    update(32'h100, 1'b1, 3);
    update(32'h100, 1'b0, 4);
    predict(32'h100, 1'b0, "pred_saturated_low");
    update(32'h200, 1'b1, 2);
    predict(32'h100, 1'b1, "pred_alias_0x200");

    // Counter at 0x100 is 2; a same-cycle not-taken update must drop the prediction.
    set_pred(1'b1, 32'h100);
    set_res(1'b1, 32'h100, OP_BR, 3'b000, 32'h0, 32'h1, 1'b0);
    tick();
    check("bypass_pred", {31'b0, pred_taken_out}, 32'd0);
    set_pred(1'b0, 32'h0);

    set_res(1'b1, 32'h100, OP_JAL, 3'b000, 32'h0, 32'h0, 1'b0);
    tick();
    check("jal_mispredict", {31'b0, mispredict_out}, 32'd1);
    predict(32'h100, 1'b0, "jal_no_bht_update");
    check("mispredict_one_pulse", {31'b0, mispredict_out}, 32'd0);

    set_res(1'b1, 32'h100, OP_BR, 3'b000, 32'h3, 32'h3, 1'b1);
    tick();
    check("beq_correct_no_pulse", {31'b0, mispredict_out}, 32'd0);
    set_res(1'b1, 32'h100, OP_JALR, 3'b001, 32'h0, 32'h0, 1'b1);
    tick();
    check("jalr_f3_001_no_pulse", {30'b0, branch_taken_out, mispredict_out}, 32'd0);
    set_res(1'b1, 32'h100, OP_BR, 3'b010, 32'h0, 32'h0, 1'b1);
    tick();
    check("illegal_no_pulse", {31'b0, mispredict_out}, 32'd0);
    predict(32'h100, 1'b1, "illegal_no_bht_update");

    set_res(1'b1, 32'h104, OP_JAL, 3'b000, 32'h0, 32'h0, 1'b0);
    tick();
    check("b2b_pulse_1", {31'b0, mispredict_out}, 32'd1);
    tick();
    check("b2b_pulse_2", {31'b0, mispredict_out}, 32'd1);
    set_res(1'b0, 32'h0, 5'b0, 3'b0, 32'h0, 32'h0, 1'b0);
    tick();
    check("b2b_pulse_end", {31'b0, mispredict_out}, 32'd0);

    // Performance counters: 17 counted resolutions, 3 of them mispredicted.
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    repeat (NENT) tick();
    check("perf_ready", {31'b0, ready_out}, 32'd1);
    for (int i = 0; i < 17; i++) begin
      set_res(1'b1, 32'h300, OP_JAL, 3'b000, 32'h0, 32'h0, (i < 3) ? 1'b0 : 1'b1);
      tick();
    end
    set_res(1'b0, 32'h0, 5'b0, 3'b0, 32'h0, 32'h0, 1'b0);
    tick();
`ifdef MSRV32_BP_PERF_EN
    check("perf_branch_cnt", 32'(branch_cnt_out), 32'd1);
    check("perf_mispred_cnt", 32'(mispred_cnt_out), 32'd3);
`else
    check("perf_branch_cnt_off", 32'(branch_cnt_out), 32'd0);
    check("perf_mispred_cnt_off", 32'(mispred_cnt_out), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
